// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-wide RAM initiator: size codes, FSM states and size helpers.
package mem_ctrl_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // Index of the last byte of a transfer (N-1); the reserved code behaves as a word.
  function automatic logic [1:0] last_byte(input logic [1:0] size);
    case (size)
      MEM_SIZE_B: last_byte = 2'd0;
      MEM_SIZE_H: last_byte = 2'd1;
      default:    last_byte = 2'd3;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      MEM_SIZE_B: misaligned = 1'b0;
      MEM_SIZE_H: misaligned = addr_lo[0];
      default:    misaligned = |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_lane.sv
// Byte-lane helper: size decode, write-byte select and read-byte insert for the 32-bit core data.
module mem_ctrl_lane
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  wsel_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  rsel_i,
  input  logic [31:0] rbuf_i,
  input  logic [7:0]  rbyte_i,
  output logic [1:0]  last_o,
  output logic [7:0]  wbyte_o,
  output logic [31:0] rbuf_o
);

  always_comb begin
    last_o  = last_byte(size_i);
    wbyte_o = wdata_i[8*wsel_i +: 8];
    rbuf_o  = rbuf_i;
    rbuf_o[8*rsel_i +: 8] = rbyte_i;
  end

endmodule

// File: rtl/mem_ctrl.sv
// Sequences one 8/16/32-bit core request into byte accesses on the on-board RAM.
// Optional MEM_CTRL_ALIGN_CHECK_EN rejects misaligned half/word requests with an error response.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic                  req_we_in,
  input  logic [1:0]            req_size_in,
  input  logic [ADDR_WIDTH-1:0] req_addr_in,
  input  logic [31:0]           req_wdata_in,
  output logic                  resp_valid_out,
  output logic [31:0]           resp_rdata_out,
  output logic                  resp_err_out,
  output logic                  ram_en_out,
  output logic                  ram_r_nw_out,
  output logic [ADDR_WIDTH-1:0] ram_a_out,
  output logic [7:0]            ram_d_out,
  input  logic [7:0]            ram_d_in,
  output state_t                dbg_state_out
);

  // Handshake: a request transfers on a rising edge where req_valid_in and req_ready_out are both 1;
  // ready is high only in IDLE and inputs are captured only at that edge.

  state_t                state_q, state_d;
  logic [1:0]            k_q, k_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rbuf_q, rbuf_d;
  logic                  ready_q, ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  en_q, en_d;
  logic                  r_nw_q, r_nw_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic [7:0]            d_q, d_d;

  logic        accept;
  logic        misal;
  logic [1:0]  last_w, wsel, rsel;
  logic [7:0]  wbyte;
  logic [31:0] wsrc, rbuf_ins;

  assign accept = req_valid_in && ready_q;

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  logic err_q, err_d;
  assign misal = misaligned(req_size_in, req_addr_in[1:0]);

  always_comb begin
    err_d = err_q;
    if (state_q == ST_IDLE && accept) err_d = misal;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) err_q <= 1'b0;
    else           err_q <= err_d;
  end

  assign resp_err_out = err_q;
`else
  assign misal        = 1'b0;
  assign resp_err_out = 1'b0;
`endif

  // In IDLE the lane selects byte 0 of the incoming request; otherwise the next byte to drive.
  assign wsrc = (state_q == ST_IDLE) ? req_wdata_in : wdata_q;
  assign wsel = (state_q == ST_IDLE) ? 2'd0 : k_q + 2'd1;
  assign rsel = (state_q == ST_DRAIN) ? k_q : k_q - 2'd1;

  mem_ctrl_lane u_lane (
    .size_i  (size_q),
    .wsel_i  (wsel),
    .wdata_i (wsrc),
    .rsel_i  (rsel),
    .rbuf_i  (rbuf_q),
    .rbyte_i (ram_d_in),
    .last_o  (last_w),
    .wbyte_o (wbyte),
    .rbuf_o  (rbuf_ins)
  );

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    we_d         = we_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rbuf_d       = rbuf_q;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;
    en_d         = en_q;
    r_nw_d       = r_nw_q;
    a_d          = a_q;
    d_d          = d_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = req_we_in;
          size_d  = req_size_in;
          addr_d  = req_addr_in;
          wdata_d = req_wdata_in;
          k_d     = 2'd0;
          rbuf_d  = '0;
          if (misal) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            rdata_d      = '0;
          end else begin
            state_d = req_we_in ? ST_WRITE : ST_READ;
            en_d    = 1'b1;
            r_nw_d  = ~req_we_in;
            a_d     = req_addr_in;
            if (req_we_in) d_d = wbyte;
          end
        end
      end
      ST_WRITE: begin
        if (k_q == last_w) begin
          state_d      = ST_RESP;
          en_d         = 1'b0;
          r_nw_d       = 1'b1;
          resp_valid_d = 1'b1;
          rdata_d      = '0;
        end else begin
          k_d = k_q + 2'd1;
          a_d = addr_q + ADDR_WIDTH'(k_q + 2'd1);
          d_d = wbyte;
        end
      end
      ST_READ: begin
        // RAM data lags the address by one cycle, so byte k-1 is arriving now.
        if (k_q != 2'd0) rbuf_d = rbuf_ins;
        if (k_q == last_w) begin
          state_d = ST_DRAIN;
        end else begin
          k_d = k_q + 2'd1;
          a_d = addr_q + ADDR_WIDTH'(k_q + 2'd1);
        end
      end
      ST_DRAIN: begin
        state_d      = ST_RESP;
        en_d         = 1'b0;
        resp_valid_d = 1'b1;
        rdata_d      = rbuf_ins;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
        r_nw_d  = 1'b1;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_IDLE;
      k_q          <= 2'd0;
      we_q         <= 1'b0;
      size_q       <= MEM_SIZE_B;
      addr_q       <= '0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      en_q         <= 1'b0;
      r_nw_q       <= 1'b1;
      a_q          <= '0;
      d_q          <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      we_q         <= we_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rbuf_q       <= rbuf_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      en_q         <= en_d;
      r_nw_q       <= r_nw_d;
      a_q          <= a_d;
      d_q          <= d_d;
    end
  end

  assign req_ready_out  = ready_q;
  assign resp_valid_out = resp_valid_q;
  assign resp_rdata_out = rdata_q;
  assign ram_en_out     = en_q;
  assign ram_r_nw_out   = r_nw_q;
  assign ram_a_out      = a_q;
  assign ram_d_out      = d_q;
  assign dbg_state_out  = state_q;

endmodule
